// File: rtl/xylo_pkg.sv
// xylo_pkg: shared types and the default song table for the xylo sequencer.
//   state_t      FSM states {IDLE, LOAD, PLAY, GAP, DONE}
//   END_CODE     note code that marks the end of the song
//   rom_entry_t  {beats_m1[1:0], code[3:0]}; a note lasts beats_m1+1 beats
//   SONG         default song table
//   song_entry() bounds-checked table read; out-of-table reads return the end marker
package xylo_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] END_CODE = 4'hF;

    typedef struct packed {
        logic [1:0] beats_m1;
        logic [3:0] code;
    } rom_entry_t;

    localparam int SONG_LEN = 8;

    localparam rom_entry_t SONG [SONG_LEN] = '{
        '{beats_m1: 2'd0, code: 4'd0},
        '{beats_m1: 2'd0, code: 4'd2},
        '{beats_m1: 2'd1, code: 4'd4},
        '{beats_m1: 2'd0, code: 4'd5},
        '{beats_m1: 2'd0, code: 4'd7},
        '{beats_m1: 2'd1, code: 4'd9},
        '{beats_m1: 2'd3, code: 4'd11},
        '{beats_m1: 2'd0, code: END_CODE}
    };

    function automatic rom_entry_t song_entry(input int unsigned idx);
        rom_entry_t e;
        e = '{beats_m1: 2'd0, code: END_CODE};
        if (idx < SONG_LEN) begin
            e = SONG[idx[2:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/xylo_beat_timer.sv
// xylo_beat_timer: measures the hold time of one note.
//   clock, reset  clock / synchronous active-high reset
//   load          restarts the timer with a new beat count (also used as clear)
//   en            timer advances only while enabled (note is playing)
//   beats_m1      number of beats minus one for the note being loaded
//   expire        high on the last cycle of (beats_m1+1)*TICKS_PER_BEAT enabled cycles
module xylo_beat_timer #(
    parameter int TICKS_PER_BEAT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [1:0] beats_m1,
    output logic       expire
);

    localparam int PW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_BEAT - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    beat_q,  beat_d;
    logic          last_tick;

    assign last_tick = (presc_q == LAST_TICK);

    always_comb begin
        presc_d = presc_q;
        beat_d  = beat_q;
        if (load) begin
            presc_d = '0;
            beat_d  = beats_m1;
        end else if (en) begin
            if (last_tick) begin
                presc_d = '0;
                beat_d  = beat_q - 2'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            beat_q  <= '0;
        end else begin
            presc_q <= presc_d;
            beat_q  <= beat_d;
        end
    end

    assign expire = en && !load && last_tick && (beat_q == 2'd0);

endmodule

// File: rtl/xylo_sequencer.sv
// xylo_sequencer: plays the song table from xylo_pkg::SONG into a Notas decoder.
//   clock, reset  clock / synchronous active-high reset
//   start         level; begins playback from entry 0 when in IDLE or DONE
//   stop          aborts playback (wins over start), returns to IDLE
//   a,b,c,d       current note code, a = MSB
//   ready         one-cycle strobe on the first cycle a note is presented
//   busy          high in LOAD/PLAY/GAP
//   done          high in DONE
//   pos           index of the entry being played
// Build option: define XYLO_LOOP_EN to repeat the song forever instead of
// finishing in DONE.
module xylo_sequencer
    import xylo_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 4,
    parameter int ROM_DEPTH      = 8,
    parameter int IDX_W          = $clog2(ROM_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pos
);

    // pos carries one extra bit so stepping past the last entry is visible
    // in LOAD instead of silently wrapping to entry 0.
    localparam logic [IDX_W:0] LAST_POS = (IDX_W + 1)'(ROM_DEPTH - 1);

    state_t         state_q, state_d;
    logic [IDX_W:0] pos_q,   pos_d;
    logic [3:0]     code_q,  code_d;
    logic           ready_q, ready_d;

    rom_entry_t     entry;
    logic           song_end;
    logic           tmr_load;
    logic           tmr_expire;

    assign entry    = song_entry(32'(pos_q));
    assign song_end = (pos_q > LAST_POS) || (entry.code == END_CODE);

    xylo_beat_timer #(
        .TICKS_PER_BEAT(TICKS_PER_BEAT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .en      (state_q == PLAY),
        .beats_m1(entry.beats_m1),
        .expire  (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        code_d   = code_q;
        ready_d  = 1'b0;
        tmr_load = 1'b0;

        if (stop && state_q != IDLE) begin
            state_d  = IDLE;
            pos_d    = '0;
            code_d   = '0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = LOAD;
                        pos_d   = '0;
                    end
                end
                LOAD: begin
                    if (song_end) begin
`ifdef XYLO_LOOP_EN
                        // Wrap: note code stays on a..d until the next PLAY entry.
                        state_d = LOAD;
                        pos_d   = '0;
`else
                        state_d = DONE;
                        code_d  = '0;
`endif
                    end else begin
                        state_d  = PLAY;
                        code_d   = entry.code;
                        ready_d  = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                PLAY: begin
                    if (tmr_expire) begin
                        state_d = GAP;
                    end
                end
                GAP: begin
                    state_d = LOAD;
                    pos_d   = pos_q + (IDX_W + 1)'(1);
                end
                DONE: begin
                    if (start) begin
                        state_d = LOAD;
                        pos_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            code_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
            ready_q <= ready_d;
        end
    end

    assign {a, b, c, d} = code_q;
    assign ready        = ready_q;
    assign busy         = (state_q == LOAD) || (state_q == PLAY) || (state_q == GAP);
    assign done         = (state_q == DONE);
    assign pos          = pos_q[IDX_W-1:0];

endmodule

// File: tb/tb_xylo_sequencer.sv
// Bench for xylo_sequencer: the expected outputs come from a timeline model of
// the song (cycle offset since start -> what must be on the outputs), plus a
// few literal timing points for the full-song run.
module tb_xylo_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, stop;
    logic       a, b, c, d, ready, busy, done;
    logic [2:0] pos;

    always #5 clock = ~clock;

    xylo_sequencer #(
        .TICKS_PER_BEAT(4),
        .ROM_DEPTH     (8),
        .IDX_W         (3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stop (stop),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .ready(ready),
        .busy (busy),
        .done (done),
        .pos  (pos)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int song_code  [8] = '{0, 2, 4, 5, 7, 9, 11, 15};
    int song_beats [8] = '{1, 1, 2, 1, 1, 2, 4, 1};

    // Expected outputs k cycles after the cycle in which start was accepted.
    // Each note occupies one LOAD cycle, beats*4 PLAY cycles and one GAP cycle.
    function automatic void timeline(input int k, output logic bz, output logic dn,
                                     output logic rd, output logic [3:0] cd,
                                     output logic [2:0] ps);
        int off, i, hold;
        logic [3:0] last;
        bz = 0; dn = 0; rd = 0; cd = 0; ps = 0;
        off = 1; i = 0; last = 0;
        while (1) begin
            if (i >= 8 || song_code[i] == 15) begin
                if (k == off) begin
                    bz = 1; ps = 3'(i); cd = last;
                    return;
                end
`ifdef XYLO_LOOP_EN
                off = off + 1;
                i = 0;
                continue;
`else
                dn = 1; ps = 3'(i); cd = 0;
                return;
`endif
            end
            hold = song_beats[i] * 4;
            if (k == off) begin
                bz = 1; ps = 3'(i); cd = last;
                return;
            end
            if (k <= off + hold + 1) begin
                bz = 1; ps = 3'(i); cd = 4'(song_code[i]);
                rd = (k == off + 1);
                return;
            end
            last = 4'(song_code[i]);
            off  = off + hold + 2;
            i    = i + 1;
        end
    endfunction

    int cyc = 0;
    int s_cyc = 0;
    bit run = 0;
    bit chk = 0;

    // Reference: track whether a song is running and when it was started.
    always @(posedge clock) begin : model
        logic bz, dn, rd;
        logic [3:0] cd;
        logic [2:0] ps;
        dn = 0;
        if (run) timeline(cyc - s_cyc, bz, dn, rd, cd, ps);
        if (reset) begin
            run = 0;
            chk = 1;
        end else if (stop) begin
            run = 0;
        end else if (start && (!run || dn)) begin
            run = 1;
            s_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    always @(negedge clock) begin : compare
        logic eb, ed, er;
        logic [3:0] ec;
        logic [2:0] ep;
        if (chk) begin
            eb = 0; ed = 0; er = 0; ec = 0; ep = 0;
            if (run) timeline(cyc - s_cyc, eb, ed, er, ec, ep);
            n_cmp = n_cmp + 1;
            if ({busy, done, ready, a, b, c, d, pos} !== {eb, ed, er, ec, ep}) begin
                n_bad = n_bad + 1;
                $display("FAIL outputs cycle %0d: busy/done/ready/abcd/pos got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         cyc, busy, done, ready, {a, b, c, d}, pos, eb, ed, er, ec, ep);
            end
        end
    end

    // Literal checkpoints for the full-song run.
    int mon_s;
    bit mon = 0;
    int rq_off [$];
    logic [3:0] rq_cd [$];
    int exp_off [7] = '{2, 8, 14, 24, 30, 36, 46};
    logic [3:0] exp_cd [7] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h9, 4'hB};

    always @(negedge clock) begin : monitor
        if (mon) begin
            if (ready && (cyc - mon_s) < 64) begin
                rq_off.push_back(cyc - mon_s);
                rq_cd.push_back({a, b, c, d});
            end
`ifdef XYLO_LOOP_EN
            if (cyc - mon_s == 64) begin
                n_cmp = n_cmp + 1;
                if (!(busy && !done && !ready && pos == 3'd0)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL wrap_load: busy/done/ready/pos got %b/%b/%b/%0d want 1/0/0/0",
                             busy, done, ready, pos);
                end
            end
            if (cyc - mon_s == 65) begin
                n_cmp = n_cmp + 1;
                if (!(ready && !done && {a, b, c, d} == 4'h0)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL wrap_ready: ready/done/abcd got %b/%b/%b want 1/0/0000",
                             ready, done, {a, b, c, d});
                end
            end
`else
            if (cyc - mon_s == 64) begin
                n_cmp = n_cmp + 1;
                if (!(done && !busy && {a, b, c, d} == 4'h0)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL song_done: done/busy/abcd got %b/%b/%b want 1/0/0000",
                             done, busy, {a, b, c, d});
                end
            end
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        reset = 1; start = 0; stop = 0;
        step(3);
        reset = 0;
        step(2);

        // Full song, with a start pulse at S+3 that must be ignored.
        start = 1; mon_s = cyc; mon = 1;
        step(1); start = 0;
        step(2); start = 1;
        step(1); start = 0;
        step(70);
        mon = 0;
        n_cmp = n_cmp + 1;
        if (rq_off.size() != 7) begin
            n_bad = n_bad + 1;
            $display("FAIL ready_count: got %0d want 7", rq_off.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp = n_cmp + 1;
                if (rq_off[i] != exp_off[i] || rq_cd[i] !== exp_cd[i]) begin
                    n_bad = n_bad + 1;
                    $display("FAIL note%0d: ready at S+%0d abcd %b want S+%0d abcd %b",
                             i, rq_off[i], rq_cd[i], exp_off[i], exp_cd[i]);
                end
            end
        end

        // Restart (from DONE in the default build), then stop mid-note at S+10.
        start = 1; step(1); start = 0;
        step(9); stop = 1; step(1); stop = 0;
        step(3);
        start = 1; step(1); start = 0;
        step(6);

        // start and stop together while idle, then stop, then reset mid-song.
        stop = 1; step(1); stop = 0;
        start = 1; stop = 1; step(3); start = 0; stop = 0;
        step(4);
        start = 1; step(1); start = 0;
        step(19); reset = 1; step(1); reset = 0;
        step(2);
        start = 1; step(1); start = 0;
        step(80);

        // Randomised start/stop/reset traffic.
        repeat (4000) begin
            start = ($urandom % 16 == 0);
            stop  = ($urandom % 90 == 0);
            reset = ($urandom % 600 == 0);
            step(1);
        end
        start = 0; stop = 0; reset = 0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
